// File: rtl/mips32_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips32_ctrl_pkg : shared run-control types and constants for the MIPS32 core
// Rev 1.0
// ============================================================================
package mips32_ctrl_pkg;

  localparam int AW_DEF          = 10;
  localparam int DW_DEF          = 32;
  localparam int RESULT_ADDR_DEF = 198;
  localparam logic [5:0] OPC_HLT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_RD    = 3'd4,
    ST_CAP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } run_state_e;

endpackage
`default_nettype wire

// File: rtl/mips32_watchdog.sv
`default_nettype none
// ============================================================================
// mips32_watchdog : saturating RUN-cycle counter with timeout compare
// Optional watchdog abort enabled by MIPS32_RUN_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module mips32_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  output logic [31:0] count,
  output logic        expired
);

`ifdef MIPS32_RUN_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  localparam logic [31:0] LIMIT = 32'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

  // Compare against the pre-increment value: the TIMEOUT-th RUN cycle aborts.
  assign expired = WD_ON && en && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mips32_run_ctrl.sv
`default_nettype none
// ============================================================================
// mips32_run_ctrl : load / run / read-back sequencer for the MIPS32 core
// Watchdog abort enabled by MIPS32_RUN_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module mips32_run_ctrl
  import mips32_ctrl_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT     = 4096,
  parameter int RESULT_ADDR = RESULT_ADDR_DEF
) (
  input  logic          clk_1,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          start,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          core_hold,
  input  logic          core_halted,
  output logic          dmem_re,
  output logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [DW-1:0] result,
  output logic [31:0]   cycle_cnt
);

  run_state_e    state;
  logic [AW-1:0] load_addr;
  logic          xfer;
  logic          run_go;
  logic          wd_en;
  logic          wd_expired;

  // The write lands on the same edge as the handshake.
  assign xfer       = ld_valid & ld_ready;
  assign imem_we    = xfer;
  assign imem_addr  = load_addr;
  assign imem_wdata = ld_data;

  // ld_valid outranks start, and start is ignored before a program is loaded.
  assign run_go = start && !ld_valid && (state inside {ST_READY, ST_DONE, ST_ERR});
  assign wd_en  = (state == ST_RUN);

  mips32_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk_1),
    .rst     (rst),
    .clear   (run_go),
    .en      (wd_en),
    .count   (cycle_cnt),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state     <= ST_IDLE;
      load_addr <= '0;
      ld_ready  <= 1'b0;
      core_hold <= 1'b1;
      dmem_re   <= 1'b0;
      dmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
    end else begin
      dmem_re <= 1'b0;
      case (state)
        ST_IDLE, ST_READY, ST_DONE, ST_ERR: begin
          if (ld_valid) begin
            state     <= ST_LOAD;
            load_addr <= '0;
            ld_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end else if (run_go) begin
            state     <= ST_RUN;
            core_hold <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            load_addr <= load_addr + AW'(1);
            // Filling the top word ends the load even without ld_last.
            if (ld_last || (load_addr == '1)) begin
              state    <= ST_READY;
              ld_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (core_halted) begin
            state     <= ST_RD;
            core_hold <= 1'b1;
            dmem_re   <= 1'b1;
            dmem_addr <= AW'(RESULT_ADDR);
          end else if (wd_expired) begin
            state     <= ST_ERR;
            core_hold <= 1'b1;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          result <= dmem_rdata;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_run_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips32_run_ctrl : randomized bench with a behavioural core and memories
// Rev 1.0
// ============================================================================
module tb_mips32_run_ctrl;
  import mips32_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam int RA = RESULT_ADDR_DEF;

  logic          clk_1 = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, imem_we, core_hold, dmem_re, busy, done, timeout;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] imem_wdata, result;
  logic [31:0]   cycle_cnt;
  logic          core_halted = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_1 = ~clk_1;

  mips32_run_ctrl #(
    .AW(AW), .DW(DW), .TIMEOUT(TO), .RESULT_ADDR(RA)
  ) dut (
    .clk_1(clk_1), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .core_halted(core_halted), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .busy(busy), .done(done), .timeout(timeout),
    .result(result), .cycle_cnt(cycle_cnt)
  );

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Behavioural core: runs while released, halts after halt_after cycles
  // (0 = never) and leaves n! in the result word of data memory.
  int unsigned   halt_after = 0;
  int unsigned   core_cycles = 0;
  logic [31:0]   fact_in = 32'd0;
  logic [31:0]   res_word = 32'd0;

  always @(posedge clk_1) begin
    if (core_hold) begin
      core_cycles <= 0;
      core_halted <= 1'b0;
    end else begin
      core_cycles <= core_cycles + 1;
      if (halt_after != 0 && core_cycles + 1 == halt_after) begin
        core_halted <= 1'b1;
        res_word    <= fact(fact_in);
      end
    end
    if (dmem_re)
      dmem_rdata <= (dmem_addr == AW'(RA)) ? res_word : ({22'h0, dmem_addr} ^ 32'hA5A5_0000);
  end

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            re_count = 0;
  int            re_bad = 0;

  always @(posedge clk_1) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (dmem_re) begin
      re_count <= re_count + 1;
      if (dmem_addr != AW'(RA)) re_bad <= re_bad + 1;
    end
  end

  logic [DW-1:0] prog[0:1023];
  logic [DW-1:0] exp_result = '0;
  localparam logic [31:0] FACT_PROG[10] = '{
    32'h280A00C8, 32'h28020001, 32'h0E94A000, 32'h21430000, 32'h0E94A000,
    32'h14431000, 32'h2C630001, 32'h00832800, 32'h2543FFFE, {OPC_HLT, 26'd0}
  };

  // mode 0: ld_valid always high, 1: alternating 1/0, 2: random
  task automatic load_prog(input int n, input int mode, input bit use_last);
    int idx = 0;
    int guard = 0;
    int base = wr_addr_q.size();
    bit v, will;
    while (idx < n && guard < 8 * n + 40) begin
      @(negedge clk_1);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      ld_valid = v;
      ld_data  = prog[idx];
      ld_last  = use_last && (idx == n - 1);
      #1;
      if (!v) begin
        checks++;
        if (imem_we !== 1'b0) begin
          errors++;
          $display("FAIL load_gap_we: imem_we=%b required 0", imem_we);
        end
      end
      will = v && ld_ready;
      @(posedge clk_1);
      if (will) idx++;
      guard++;
    end
    @(negedge clk_1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (idx != n || (wr_addr_q.size() - base) != n) begin
      errors++;
      $display("FAIL load_count: accepted=%0d writes=%0d required %0d", idx, wr_addr_q.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_addr_q[base+i] !== AW'(i) || wr_data_q[base+i] !== prog[i]) begin
          errors++;
          $display("FAIL load_write[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                   i, wr_addr_q[base+i], wr_data_q[base+i], i, prog[i]);
        end
      end
    end
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_state: ld_ready=%b busy=%b core_hold=%b required 0 0 1",
               ld_ready, busy, core_hold);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_1);
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1 || timeout === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_1);
    checks++;
    if ({ld_ready, imem_we, core_hold, dmem_re, busy, done, timeout} !== 7'b0010000 ||
        imem_addr !== '0 || dmem_addr !== '0 || result !== '0 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b hold=%b re=%b busy=%b done=%b to=%b ia=%0d da=%0d res=%h cnt=%0d required hold=1 rest 0",
               ld_ready, imem_we, core_hold, dmem_re, busy, done, timeout, imem_addr, dmem_addr, result, cycle_cnt);
    end
    rst = 1'b0;
    pulse_start();
    checks++;
    if (core_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_idle: core_hold=%b busy=%b required 1 0", core_hold, busy);
    end
  endtask

  task automatic test_run(input logic [31:0] arg, input bit reload);
    int unsigned h;
    int re0;
    bit ok;
    if (reload) begin
      for (int i = 0; i < 10; i++) prog[i] = FACT_PROG[i];
      load_prog(10, 2, 1'b1);
    end
    fact_in    = arg;
    h          = $urandom_range(5, 40);
    halt_after = h;
    re0        = re_count;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || core_hold !== 1'b0 || done !== 1'b0 || cycle_cnt !== 32'd0 || result !== exp_result) begin
      errors++;
      $display("FAIL run_entry: busy=%b hold=%b done=%b cnt=%0d result=%h required 1 0 0 0 %h",
               busy, core_hold, done, cycle_cnt, result, exp_result);
    end
    wait_end(200, ok);
    exp_result = fact(arg);
    checks++;
    if (!ok || done !== 1'b1 || timeout !== 1'b0 || result !== exp_result) begin
      errors++;
      $display("FAIL run_result(%0d): done=%b timeout=%b result=%0d required 1 0 %0d",
               arg, done, timeout, result, exp_result);
    end
    // The halt flag is seen by the sequencer one edge after the core raises it.
    checks++;
    if (cycle_cnt !== 32'(h + 1) || core_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_cycles: cycle_cnt=%0d hold=%b busy=%b required %0d 1 0", cycle_cnt, core_hold, busy, h + 1);
    end
    checks++;
    if (re_count - re0 != 1 || re_bad != 0) begin
      errors++;
      $display("FAIL run_readback: reads=%0d bad_addr=%0d required 1 0", re_count - re0, re_bad);
    end
  endtask

  task automatic test_gapped_load();
    for (int i = 0; i < 4; i++) prog[i] = $urandom;
    load_prog(4, 1, 1'b1);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 1024; i++) prog[i] = $urandom;
    load_prog(1024, 0, 1'b0);
  endtask

  task automatic test_timeout();
    bit ok;
    prog[0] = 32'h1000FFFF;
    prog[1] = 32'h00000000;
    load_prog(2, 0, 1'b1);
    halt_after = 0;
    pulse_start();
`ifdef MIPS32_RUN_TIMEOUT_EN
    wait_end(TO + 20, ok);
    checks++;
    if (!ok || timeout !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: timeout=%b done=%b hold=%b busy=%b required 1 0 1 0", timeout, done, core_hold, busy);
    end
    checks++;
    if (cycle_cnt !== 32'(TO) || result !== exp_result) begin
      errors++;
      $display("FAIL timeout_count: cycle_cnt=%0d result=%h required %0d %h", cycle_cnt, result, TO, exp_result);
    end
`else
    wait_end(TO + 20, ok);
    checks++;
    if (ok || timeout !== 1'b0 || core_hold !== 1'b0 || busy !== 1'b1 || cycle_cnt !== 32'(TO + 20)) begin
      errors++;
      $display("FAIL no_watchdog: timeout=%b hold=%b busy=%b cnt=%0d required 0 0 1 %0d",
               timeout, core_hold, busy, cycle_cnt, TO + 20);
    end
    @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    rst = 1'b0;
    exp_result = '0;
`endif
  endtask

  task automatic test_rst_mid_run();
    prog[0] = 32'h1000FFFF;
    load_prog(1, 0, 1'b1);
    halt_after = 0;
    pulse_start();
    repeat (9) @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    rst = 1'b0;
    checks++;
    if (core_hold !== 1'b1 || busy !== 1'b0 || cycle_cnt !== 32'd0 || done !== 1'b0 ||
        timeout !== 1'b0 || result !== '0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: hold=%b busy=%b cnt=%0d done=%b to=%b res=%h rdy=%b required 1 0 0 0 0 0 0",
               core_hold, busy, cycle_cnt, done, timeout, result, ld_ready);
    end
    exp_result = '0;
  endtask

  task automatic test_start_vs_load();
    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    load_prog(3, 0, 1'b1);
    @(negedge clk_1);
    start    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = prog[0];
    ld_last  = 1'b0;
    @(negedge clk_1);
    start    = 1'b0;
    ld_valid = 1'b0;
    checks++;
    if (ld_ready !== 1'b1 || core_hold !== 1'b1 || busy !== 1'b1 || cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL start_vs_load: ld_ready=%b hold=%b busy=%b cnt=%0d required 1 1 1 0",
               ld_ready, core_hold, busy, cycle_cnt);
    end
    load_prog(3, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_run(32'd5, 1'b1);
    test_run(32'd7, 1'b0);
    for (int k = 0; k < 3; k++) test_run(32'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
    test_gapped_load();
    test_full_load();
    test_timeout();
    test_rst_mid_run();
    test_start_vs_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
